mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Main control unit for the multicycle ARM datapath.
- Decodes the latched instruction fields and sequences fetch, decode, execute, memory and writeback over 3–5 cycles per instruction.
- Drives every mux select and write enable in the datapath.
- Gates architectural writes with a condition-pass bit registered at DECODE. The pass bit comes from the existing condlogic flag evaluation.

Parameters:
- RESET_STATE, FETCH: state entered on reset.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- Op  in  2  instr[27:26]
- Funct  in  6  instr[25:20]
- Rd  in  4  instr[15:12]
- CondEx  in  1  condition pass from condlogic, valid during DECODE
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register enable
- ResultSrc  out  2  result select: 00=ALUOut, 01=ReadData, 10=ALUResult
- ALUSrcA  out  1  ALU A select: 0=register, 1=PC
- ALUSrcB  out  2  ALU B select: 00=register, 01=ExtImm, 10=constant 4
- ALUControl  out  4  ALU operation
- ImmSrc  out  2  extend mode; equals Op
- RegSrc  out  2  register-address selects
- RegWrite  out  1  register file write enable
- FlagWrite  out  2  [1]=NZ update, [0]=CV update
- IllegalInstr  out  1  sticky illegal-instruction indicator (macro only; otherwise tied 0)

Behaviour:
- Structure: Moore FSM with state register clocked on posedge clk.
- Reset: asynchronous. State goes to FETCH, cond_q=0, IllegalInstr=0. While reset is high, PCWrite, IRWrite, RegWrite, MemWrite and FlagWrite are forced 0 combinationally. Selects take their FETCH values.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, NextPC=1. Next state DECODE.
- DECODE:
  - Selects as in FETCH (produces PC+8). cond_q <= CondEx.
  - Next state by Op: 01 → MEMADR; 00 with Funct[5]=0 → EXECUTER; 00 with Funct[5]=1 → EXECUTEI; 10 → BRANCH; 11 or unsupported cmd → UNKNOWN.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Funct[0]=1 → MEMRD, else → MEMWR.
- MEMRD: AdrSrc=1. Next state MEMWB.
- MEMWB: ResultSrc=01, RegW=1. Next state FETCH.
- MEMWR: AdrSrc=1, MemW=1. Next state FETCH.
- EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUControl from cmd. Next state ALUWB.
- EXECUTEI: as EXECUTER but ALUSrcB=01. Next state ALUWB.
- ALUWB:
  - ResultSrc=00; RegW=~NoWrite.
  - FlagW[1]=S, FlagW[0]=S&(ADD|SUB); CMP forces FlagW=11.
  - Next state FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, Branch=1. Next state FETCH.
- UNKNOWN: no writes. Next state FETCH.
- cmd = Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 0001 EOR, 1101 MOV, 1010 CMP. CMP uses SUB with NoWrite=1.
- Gating:
  - RegWrite=RegW&cond_q
  - MemWrite=MemW&cond_q
  - FlagWrite=FlagW&{2{cond_q}}
  - PCS=Branch|(RegW&Rd==15)
  - PCWrite=NextPC|(PCS&cond_q)
- RegSrc: [0]=(Op==10), [1]=(Op==01).
- Latency: LDR 5 cycles; STR, data-processing and MOV 4; B 3; unknown 3.
- Failed condition: the state sequence is unchanged, but no write enables assert.

Optional Feature:
- Macro MC_CTRL_ILLEGAL_TRAP_EN.
- When defined, UNKNOWN moves to a terminal ILLEGAL state. ILLEGAL sets IllegalInstr=1 (sticky), holds PCWrite and IRWrite at 0, and is left only by reset.
- When undefined, UNKNOWN returns to FETCH, acting as a NOP, and IllegalInstr is tied 0.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum (FETCH…ILLEGAL)
  - ALUControl 4-bit constants (ADD=0000, SUB=0001, AND=0010, ORR=0011, EOR=0100, MOV=0101)
  - cmd codes
  - ResultSrc and ALUSrcB encodings
- Combinational sub-module mc_decoder maps Op/Funct to ALUControl, FlagW, NoWrite and an illegal flag. The FSM and gating stay in mc_controller.

Test Plan:
- Reset held 3 cycles, then released → state FETCH; first cycle shows IRWrite=1, PCWrite=1, ALUSrcB=10. All writes stay 0 while reset is high.
- ADD R1,R2,#5 (Op=00, Funct=101000, CondEx=1) → sequence FETCH, DECODE, EXECUTEI, ALUWB. RegWrite=1 and FlagWrite=00 in ALUWB; returns to FETCH.
- LDR (Op=01, Funct[0]=1) → 5-cycle sequence with AdrSrc=1 in MEMRD, then ResultSrc=01 and RegWrite=1 in MEMWB. STR → MemWrite=1 in MEMWR only.
- B with CondEx=0 at DECODE (CondEx=1 afterwards) → BRANCH visited, PCWrite=0 in BRANCH. With CondEx=1 → PCWrite=1.
- CMP (Funct=110101) → FlagWrite=11, RegWrite=0 in ALUWB. MOV PC (Rd=15) → PCWrite=1 in ALUWB.
- Op=11 → macro off: FETCH follows after 3 cycles. Macro on: ILLEGAL reached, IllegalInstr=1 and held, and it clears only on async reset asserted mid-cycle.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
// Optional feature macro used by importers: MC_CTRL_ILLEGAL_TRAP_EN.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BRANCH,
        UNKNOWN,
        ILLEGAL
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;
    localparam logic [3:0] ALU_EOR = 4'b0100;
    localparam logic [3:0] ALU_MOV = 4'b0101;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

endpackage

// File: rtl/mc_decoder.sv
// Combinational data-processing decode: ALU operation, flag-write mask,
// NoWrite (compare) and an illegal-encoding flag from Op/Funct.
module mc_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] op,
    input  logic [4:0] funct_lo,
    output logic [3:0] alu_control,
    output logic [1:0] flag_w,
    output logic       no_write,
    output logic       illegal
);

    logic [3:0] cmd;
    logic       s_bit;
    logic       arith;

    assign cmd   = funct_lo[4:1];
    assign s_bit = funct_lo[0];

    always_comb begin
        alu_control = ALU_ADD;
        flag_w      = '0;
        no_write    = 1'b0;
        illegal     = 1'b0;
        arith       = 1'b0;
        if (op == OP_DP) begin
            case (cmd)
                CMD_ADD: begin alu_control = ALU_ADD; arith = 1'b1; end
                CMD_SUB: begin alu_control = ALU_SUB; arith = 1'b1; end
                CMD_AND: alu_control = ALU_AND;
                CMD_ORR: alu_control = ALU_ORR;
                CMD_EOR: alu_control = ALU_EOR;
                CMD_MOV: alu_control = ALU_MOV;
                CMD_CMP: begin alu_control = ALU_SUB; no_write = 1'b1; end
                default: illegal = 1'b1;
            endcase
            // CMP always updates all four flags, independent of S
            if (cmd == CMD_CMP) begin
                flag_w = 2'b11;
            end else begin
                flag_w = {s_bit, s_bit & arith};
            end
        end else if (op == 2'b11) begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM main controller: Moore FSM plus condition-gated write enables.
// Optional macro MC_CTRL_ILLEGAL_TRAP_EN traps unknown encodings in a sticky ILLEGAL state.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = FETCH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic       CondEx,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic       RegWrite,
    output logic [1:0] FlagWrite,
    output logic       IllegalInstr
);

    state_t     state_q, state_d;
    logic       cond_q, cond_d;

    logic       next_pc;
    logic       ir_w;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic [1:0] flag_w;
    logic       pcs;

    logic [3:0] dec_alu;
    logic [1:0] dec_flag_w;
    logic       dec_no_write;
    logic       dec_illegal;

    mc_decoder u_decoder (
        .op          (Op),
        .funct_lo    (Funct[4:0]),
        .alu_control (dec_alu),
        .flag_w      (dec_flag_w),
        .no_write    (dec_no_write),
        .illegal     (dec_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RESET_STATE;
            cond_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cond_q  <= cond_d;
        end
    end

    assign cond_d = (state_q == DECODE) ? CondEx : cond_q;

    always_comb begin
        state_d    = state_q;
        next_pc    = 1'b0;
        ir_w       = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        flag_w     = '0;
        AdrSrc     = 1'b0;
        ResultSrc  = RES_ALURESULT;
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ALUControl = ALU_ADD;
        case (state_q)
            FETCH: begin
                ir_w    = 1'b1;
                next_pc = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                case (Op)
                    OP_MEM:  state_d = MEMADR;
                    OP_DP: begin
                        if (dec_illegal) begin
                            state_d = UNKNOWN;
                        end else if (Funct[5]) begin
                            state_d = EXECUTEI;
                        end else begin
                            state_d = EXECUTER;
                        end
                    end
                    OP_BR:   state_d = BRANCH;
                    default: state_d = UNKNOWN;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b0;
                ALUSrcB = SRCB_IMM;
                state_d = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = RES_READDATA;
                reg_w     = 1'b1;
                state_d   = FETCH;
            end
            MEMWR: begin
                AdrSrc  = 1'b1;
                mem_w   = 1'b1;
                state_d = FETCH;
            end
            EXECUTER: begin
                ALUSrcA    = 1'b0;
                ALUSrcB    = SRCB_REG;
                ALUControl = dec_alu;
                state_d    = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA    = 1'b0;
                ALUSrcB    = SRCB_IMM;
                ALUControl = dec_alu;
                state_d    = ALUWB;
            end
            ALUWB: begin
                ResultSrc = RES_ALUOUT;
                reg_w     = ~dec_no_write;
                flag_w    = dec_flag_w;
                state_d   = FETCH;
            end
            BRANCH: begin
                ALUSrcA = 1'b0;
                ALUSrcB = SRCB_IMM;
                branch  = 1'b1;
                state_d = FETCH;
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            UNKNOWN: state_d = ILLEGAL;
            ILLEGAL: state_d = ILLEGAL;
`else
            UNKNOWN: state_d = FETCH;
            ILLEGAL: state_d = FETCH;
`endif
            default: state_d = FETCH;
        endcase
    end

    // Architectural writes use the pass bit captured at DECODE; fetch-side
    // enables are unconditional. Reset masks every enable combinationally.
    assign pcs       = branch | (reg_w & (Rd == 4'd15));
    assign PCWrite   = ~reset & (next_pc | (pcs & cond_q));
    assign IRWrite   = ~reset & ir_w;
    assign RegWrite  = ~reset & reg_w & cond_q;
    assign MemWrite  = ~reset & mem_w & cond_q;
    assign FlagWrite = {2{~reset}} & flag_w & {2{cond_q}};

    assign ImmSrc = Op;
    assign RegSrc = {Op == OP_MEM, Op == OP_BR};

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    assign illegal_d = illegal_q | (state_q == UNKNOWN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign IllegalInstr = illegal_q;
`else
    assign IllegalInstr = 1'b0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed instruction table, reset
// sequences and randomized instructions against an instruction-level model.
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       CondEx;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite, IllegalInstr;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, FlagWrite;
    logic [3:0] ALUControl;

    int n_cmp = 0;
    int n_bad = 0;

    mc_controller dut (
        .clk          (clk),
        .reset        (reset),
        .Op           (Op),
        .Funct        (Funct),
        .Rd           (Rd),
        .CondEx       (CondEx),
        .PCWrite      (PCWrite),
        .AdrSrc       (AdrSrc),
        .MemWrite     (MemWrite),
        .IRWrite      (IRWrite),
        .ResultSrc    (ResultSrc),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ALUControl   (ALUControl),
        .ImmSrc       (ImmSrc),
        .RegSrc       (RegSrc),
        .RegWrite     (RegWrite),
        .FlagWrite    (FlagWrite),
        .IllegalInstr (IllegalInstr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [19:0] obs_v;
    assign obs_v = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                    ALUControl, ImmSrc, RegSrc, RegWrite, FlagWrite};

    typedef enum {C_DP, C_LDR, C_STR, C_B, C_UNK} cls_t;

    typedef struct {
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic       cond;
        int         len;
        logic [4:0] last_wr;   // {PCWrite, MemWrite, RegWrite, FlagWrite}
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Supported data-processing commands and the ALU operation each uses.
    function automatic bit dp_alu(input logic [3:0] cmd, output logic [3:0] alu);
        logic [27:0] cmds;
        logic [27:0] alus;
        cmds = {4'h4, 4'h2, 4'h0, 4'hC, 4'h1, 4'hD, 4'hA};
        alus = {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h1};
        alu = 4'h0;
        for (int i = 0; i < 7; i++) begin
            if (cmds[i*4 +: 4] == cmd) begin
                alu = alus[i*4 +: 4];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic cls_t classify(input logic [1:0] op, input logic [5:0] funct);
        logic [3:0] a;
        case (op)
            2'd1:    return funct[0] ? C_LDR : C_STR;
            2'd2:    return C_B;
            2'd3:    return C_UNK;
            default: return dp_alu(funct[4:1], a) ? C_DP : C_UNK;
        endcase
    endfunction

    function automatic int model_len(input cls_t c);
        case (c)
            C_LDR:   return 5;
            C_STR:   return 4;
            C_DP:    return 4;
            default: return 3;
        endcase
    endfunction

    // Expected outputs (and which fields are defined) for cycle k of an instruction.
    function automatic void model(input logic [1:0] op, input logic [5:0] funct,
                                  input logic [3:0] rd, input logic cond, input int k,
                                  output logic [19:0] e, output logic [19:0] c);
        logic       pcw, adr, memw, irw, a, regw;
        logic [1:0] res, b, fw;
        logic [3:0] alu;
        logic       c_adr, c_res, c_a, c_b, c_alu;
        logic       cmp, s, arith;
        cls_t       cls;
        cls = classify(op, funct);
        {pcw, adr, memw, irw, a, regw} = '0;
        res = 2'd0; b = 2'd0; fw = 2'd0; alu = 4'd0;
        {c_adr, c_res, c_a, c_b, c_alu} = '0;
        if (k <= 1) begin
            adr = 1'b0; res = 2'd2; a = 1'b1; b = 2'd2; alu = 4'd0;
            {c_adr, c_res, c_a, c_b, c_alu} = '1;
            pcw = (k == 0);
            irw = (k == 0);
        end else begin
            case (cls)
                C_DP: begin
                    if (k == 2) begin
                        a = 1'b0; b = funct[5] ? 2'd1 : 2'd0;
                        void'(dp_alu(funct[4:1], alu));
                        {c_a, c_b, c_alu} = '1;
                    end else if (k == 3) begin
                        res = 2'd0; c_res = 1'b1;
                        cmp   = (funct[4:1] == 4'hA);
                        s     = funct[0];
                        arith = (funct[4:1] == 4'h4) || (funct[4:1] == 4'h2);
                        regw  = cond & ~cmp;
                        fw    = !cond ? 2'b00 : (cmp ? 2'b11 : {s, s & arith});
                        pcw   = cond & ~cmp & (rd == 4'd15);
                    end
                end
                C_LDR, C_STR: begin
                    if (k == 2) begin
                        a = 1'b0; b = 2'd1; alu = 4'd0;
                        {c_a, c_b, c_alu} = '1;
                    end else if (k == 3) begin
                        adr = 1'b1; c_adr = 1'b1;
                        memw = (cls == C_STR) & cond;
                    end else if (k == 4 && cls == C_LDR) begin
                        res = 2'd1; c_res = 1'b1;
                        regw = cond;
                        pcw  = cond & (rd == 4'd15);
                    end
                end
                C_B: begin
                    if (k == 2) begin
                        a = 1'b0; b = 2'd1; alu = 4'd0; res = 2'd2;
                        {c_a, c_b, c_alu, c_res} = '1;
                        pcw = cond;
                    end
                end
                default: ;
            endcase
        end
        e = {pcw, adr, memw, irw, res, a, b, alu, op, op == 2'd1, op == 2'd2, regw, fw};
        c = {1'b1, c_adr, 1'b1, 1'b1, {2{c_res}}, c_a, {2{c_b}}, {4{c_alu}},
             2'b11, 2'b11, 1'b1, 2'b11};
    endfunction

    task automatic check_cycle(input string tag, input int k, input logic cond);
        logic [19:0] e, c;
        model(Op, Funct, Rd, cond, k, e, c);
        chk($sformatf("%s_cyc%0d", tag, k), {12'd0, obs_v & c}, {12'd0, e & c});
    endtask

    // Entered mid-cycle while the DUT is in FETCH; returns at the negedge of the next FETCH.
    task automatic run_instr(input string tag, input logic [1:0] op, input logic [5:0] funct,
                             input logic [3:0] rd, input logic cond, input int exp_len,
                             input bit chk_last, input logic [4:0] last_wr);
        int lat;
        int k;
        int mlen;
        Op = op; Funct = funct; Rd = rd; CondEx = ~cond;
        mlen = model_len(classify(op, funct));
        #1;
        check_cycle(tag, 0, cond);
        lat = 0;
        k = 1;
        while (lat == 0 && k <= 8) begin
            @(posedge clk); #1;
            CondEx = (k == 1) ? cond : ~cond;
            @(negedge clk);
            if (IRWrite === 1'b1) begin
                lat = k;
            end else begin
                if (k < mlen) check_cycle(tag, k, cond);
                if (chk_last && k == exp_len - 1)
                    chk({tag, "_last_wr"}, {27'd0, PCWrite, MemWrite, RegWrite, FlagWrite},
                        {27'd0, last_wr});
            end
            k++;
        end
        chk({tag, "_latency"}, lat, exp_len);
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
        chk({tag, "_illegal_tied"}, {31'd0, IllegalInstr}, 32'd0);
`endif
    endtask

    vec_t tbl[$];

    initial begin
        reset = 1'b1; Op = 2'd0; Funct = 6'd0; Rd = 4'd0; CondEx = 1'b0;

        tbl.push_back('{2'b00, 6'b101000, 4'd1,  1'b1, 4, 5'b00100}); // ADD R1,R2,#5
        tbl.push_back('{2'b01, 6'b011001, 4'd3,  1'b1, 5, 5'b00100}); // LDR
        tbl.push_back('{2'b01, 6'b011000, 4'd3,  1'b1, 4, 5'b01000}); // STR
        tbl.push_back('{2'b10, 6'b100000, 4'd0,  1'b0, 3, 5'b00000}); // B, cond fails
        tbl.push_back('{2'b10, 6'b100000, 4'd0,  1'b1, 3, 5'b10000}); // B, cond passes
        tbl.push_back('{2'b00, 6'b110101, 4'd0,  1'b1, 4, 5'b00011}); // CMP
        tbl.push_back('{2'b00, 6'b011010, 4'd15, 1'b1, 4, 5'b10100}); // MOV PC
        tbl.push_back('{2'b00, 6'b001001, 4'd2,  1'b0, 4, 5'b00000}); // ADDS, cond fails
        tbl.push_back('{2'b00, 6'b000101, 4'd2,  1'b1, 4, 5'b00111}); // SUBS
        tbl.push_back('{2'b00, 6'b000001, 4'd2,  1'b1, 4, 5'b00110}); // ANDS
        tbl.push_back('{2'b01, 6'b011001, 4'd15, 1'b1, 5, 5'b10100}); // LDR PC
        tbl.push_back('{2'b01, 6'b011001, 4'd4,  1'b0, 5, 5'b00000}); // LDR, cond fails
        tbl.push_back('{2'b01, 6'b011000, 4'd4,  1'b0, 4, 5'b00000}); // STR, cond fails
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
        tbl.push_back('{2'b11, 6'b000000, 4'd0,  1'b1, 3, 5'b00000}); // Op=11 NOP
        tbl.push_back('{2'b00, 6'b001110, 4'd0,  1'b1, 3, 5'b00000}); // unsupported cmd
`endif

        // Reset held for three cycles
        repeat (3) begin
            @(negedge clk);
            chk("rst_writes", {27'd0, PCWrite, MemWrite, IRWrite, RegWrite, FlagWrite}, 32'd0);
            chk("rst_selects", {26'd0, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc},
                {26'd0, 1'b0, 1'b1, 2'b10, 2'b10});
        end
        reset = 1'b0;

        foreach (tbl[i])
            run_instr($sformatf("tbl%0d", i), tbl[i].op, tbl[i].funct, tbl[i].rd,
                      tbl[i].cond, tbl[i].len, 1'b1, tbl[i].last_wr);

        // Async reset asserted mid-cycle inside ALUWB of an ADD
        Op = 2'b00; Funct = 6'b101000; Rd = 4'd1; CondEx = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("midrst_pre_regwrite", {31'd0, RegWrite}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_writes", {27'd0, PCWrite, MemWrite, IRWrite, RegWrite, FlagWrite}, 32'd0);
        chk("midrst_selects", {26'd0, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc},
            {26'd0, 1'b0, 1'b1, 2'b10, 2'b10});
        @(posedge clk); #1;
        chk("midrst_hold", {27'd0, PCWrite, MemWrite, IRWrite, RegWrite, FlagWrite}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_fetch", {30'd0, IRWrite, PCWrite}, 32'd3);

        // Randomized instruction stream
        for (int i = 0; i < 150; i++) begin
            logic [1:0] rop;
            logic [5:0] rfn;
            logic [3:0] rrd;
            logic       rc;
            rop = 2'($urandom_range(0, 3));
            rfn = 6'($urandom);
            rrd = 4'($urandom);
            rc  = 1'($urandom_range(0, 1));
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            while (classify(rop, rfn) == C_UNK) begin
                rop = 2'($urandom_range(0, 2));
                rfn = 6'($urandom);
            end
`endif
            run_instr($sformatf("rnd%0d", i), rop, rfn, rrd, rc,
                      model_len(classify(rop, rfn)), 1'b0, 5'd0);
        end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        // Trap: FETCH, DECODE, UNKNOWN, then ILLEGAL held until reset
        Op = 2'b11; Funct = 6'd0; Rd = 4'd0; CondEx = 1'b1;
        #1;
        chk("trap_fetch", {31'd0, IRWrite}, 32'd1);
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("trap_unknown_writes", {27'd0, PCWrite, MemWrite, IRWrite, RegWrite, FlagWrite}, 32'd0);
        repeat (4) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("trap_sticky", {29'd0, IllegalInstr, PCWrite, IRWrite}, 32'd4);
        end
        #2 reset = 1'b1;
        #1;
        chk("trap_clear", {31'd0, IllegalInstr}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("trap_refetch", {31'd0, IRWrite}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
